alu_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 58 +++++
 rtl/alu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencer.
//   - opcode constants (ALU function codes plus MUL and LOAD)
//   - sequencer FSM state enum
//   - flag register bit positions and helpers
package alu_seq_pkg;

    localparam int SEQ_W = 4;

    // Opcodes that map 1:1 onto ALU function codes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    // Sequencer-only opcodes
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_LOAD = 4'b1111;

    // ALU function that passes operand A through unchanged
    localparam logic [3:0] ALU_PASS_A = 4'b1111;

    // Flag register layout {Z,N,C,V}
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } seq_state_e;

    // True for opcodes executed in a single pass through the ALU
    function automatic logic is_alu_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_SRA: is_alu_op = 1'b1;
            default:                is_alu_op = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] make_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f        = '0;
        f[FLG_Z] = z;
        f[FLG_N] = n;
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequential front-end for the 4-bit combinational ALU.
//   Accepts commands on a valid/ready channel, drives the external ALU,
//   captures result and flags into acc/flags, and returns them on a
//   valid/ready response channel. Adds LOAD and a 4-step shift-add MUL
//   that reuses the ALU adder.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op/cmd_data payload
//   rsp_valid/rsp_ready        response handshake; rsp_err, acc, flags payload
//   busy                       high whenever the FSM is not IDLE
//   alu_a/alu_b/alu_func       drive to the ALU
//   alu_y, alu_z/n/c/v         result and flags back from the ALU
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W         = 4,   // must stay 4 to match the ALU
    parameter int MUL_STEPS = 4    // must equal W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_err,
    output logic [W-1:0] acc,
    output logic [3:0]   flags,
    output logic         busy,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_func,
    input  logic [W-1:0] alu_y,
    input  logic         alu_z,
    input  logic         alu_n,
    input  logic         alu_c,
    input  logic         alu_v
);

    localparam int STEP_W = $clog2(MUL_STEPS);

    seq_state_e        state_q,   state_d;
    logic [3:0]        op_q,      op_d;
    logic [W-1:0]      data_q,    data_d;
    logic [W-1:0]      acc_q,     acc_d;
    logic [3:0]        flags_q,   flags_d;
    logic              err_q,     err_d;
    logic [STEP_W-1:0] step_q,    step_d;
    logic [W-1:0]      partial_q, partial_d;
    logic [W-1:0]      mcand_q,   mcand_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            data_q    <= '0;
            acc_q     <= '0;
            flags_q   <= '0;
            err_q     <= 1'b0;
            step_q    <= '0;
            partial_q <= '0;
            mcand_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            acc_q     <= acc_d;
            flags_q   <= flags_d;
            err_q     <= err_d;
            step_q    <= step_d;
            partial_q <= partial_d;
            mcand_q   <= mcand_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        acc_d     = acc_q;
        flags_d   = flags_q;
        err_d     = err_q;
        step_d    = step_q;
        partial_d = partial_q;
        mcand_d   = mcand_q;
        // Idle drive: pass acc through so the ALU output is benign
        alu_a     = acc_q;
        alu_b     = '0;
        alu_func  = ALU_PASS_A;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    if (is_alu_op(cmd_op)) begin
                        state_d = ST_EXEC;
                    end else if (cmd_op == OP_MUL) begin
                        partial_d = '0;
                        mcand_d   = acc_q;
                        step_d    = '0;
                        state_d   = ST_MUL;
                    end else if (cmd_op == OP_LOAD) begin
                        // LOAD completes at accept; response follows next cycle
                        acc_d   = cmd_data;
                        flags_d = make_flags(cmd_data == '0, cmd_data[W-1], 1'b0, 1'b0);
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        // Illegal opcode: keep acc/flags, only raise the error
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end

            ST_EXEC: begin
                alu_a    = acc_q;
                alu_b    = data_q;
                alu_func = op_q;
                acc_d    = alu_y;
                flags_d  = make_flags(alu_z, alu_n, alu_c, alu_v);
                err_d    = 1'b0;
                state_d  = ST_RESP;
            end

            ST_MUL: begin
                // One shift-add step per cycle: add the shifted multiplicand
                // when the multiplier bit is set, otherwise pass partial through.
                alu_a     = partial_q;
                alu_b     = mcand_q;
                alu_func  = data_q[step_q] ? OP_ADD : ALU_PASS_A;
                partial_d = alu_y;
                mcand_d   = {mcand_q[W-2:0], 1'b0};
                step_d    = step_q + 1'b1;
                if (step_q == STEP_W'(MUL_STEPS - 1)) begin
                    // Product is taken mod 2^W; C/V carry no meaning here
                    acc_d   = alu_y;
                    flags_d = make_flags(alu_y == '0, alu_y[W-1], 1'b0, 1'b0);
                    err_d   = 1'b0;
                    step_d  = '0;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = err_q;
    assign acc       = acc_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural 4-bit ALU beside the DUT, a
// transaction-level reference model, a per-cycle compare process, directed
// literal checks and a randomized phase.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'h0;
    logic [3:0] cmd_data = 4'h0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_err;
    logic [3:0] acc;
    logic [3:0] flags;
    logic       busy;
    logic [3:0] alu_a, alu_b, alu_func, alu_y;
    logic       alu_z, alu_n, alu_c, alu_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.W(4), .MUL_STEPS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .acc(acc), .flags(flags), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_y(alu_y), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v)
    );

    // Behavioural ALU: returns {y, Z, N, C, V}
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] f);
        logic [4:0] s;
        logic [3:0] y;
        logic       c, v;
        s = '0; y = '0; c = 1'b0; v = 1'b0;
        case (f)
            4'h0: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (y[3] != a[3]);
            end
            4'h1: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                y = s[3:0]; c = s[4];
                v = (a[3] != b[3]) && (y[3] != a[3]);
            end
            4'h4: y = a & b;
            4'h5: y = a | b;
            4'h6: y = a ^ b;
            4'h8: y = a << b[1:0];
            4'h9: y = a >> b[1:0];
            4'hA: y = 4'($signed(a) >>> b[1:0]);
            4'hF: y = a;
            default: y = 4'h0;
        endcase
        return {y, (y == 4'h0), y[3], c, v};
    endfunction

    assign {alu_y, alu_z, alu_n, alu_c, alu_v} = alu_model(alu_a, alu_b, alu_func);

    // ---------------- reference model (transaction level) ----------------
    typedef struct packed {
        logic [3:0] acc;
        logic [3:0] flg;
        logic       err;
        logic [2:0] lat;
    } pred_t;

    function automatic pred_t predict(input logic [3:0] op, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] f);
        pred_t      p;
        logic [7:0] r;
        logic [7:0] prod;
        p = '0;
        case (op)
            4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: begin
                r = alu_model(a, d, op);
                p.acc = r[7:4]; p.flg = r[3:0]; p.err = 1'b0; p.lat = 3'd2;
            end
            4'hC: begin
                prod  = {4'h0, a} * {4'h0, d};
                p.acc = prod[3:0];
                p.flg = {(prod[3:0] == 4'h0), prod[3], 2'b00};
                p.err = 1'b0; p.lat = 3'd5;
            end
            4'hF: begin
                p.acc = d; p.flg = {(d == 4'h0), d[3], 2'b00};
                p.err = 1'b0; p.lat = 3'd1;
            end
            default: begin
                p.acc = a; p.flg = f; p.err = 1'b1; p.lat = 3'd1;
            end
        endcase
        return p;
    endfunction

    // Expected running sum of the shift-add multiply after k steps
    function automatic logic [3:0] mul_partial(input logic [3:0] a, input logic [3:0] d,
                                               input int k);
        logic [7:0] s;
        s = '0;
        for (int j = 0; j < k; j++)
            if (d[j]) s = s + ({4'h0, a} << j);
        return s[3:0];
    endfunction

    int         ph;    // 0 = idle, 1 = command accepted and not yet handed back
    int         cyc;   // cycles since accept
    pred_t      pr;
    logic [3:0] m_acc, m_flags, q_op, q_d;
    logic       m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0; cyc <= 0; pr <= '0;
            m_acc <= 4'h0; m_flags <= 4'h0; m_err <= 1'b0;
            q_op <= 4'h0; q_d <= 4'h0;
        end else if (ph == 0) begin
            if (cmd_valid) begin
                pr   <= predict(cmd_op, cmd_data, m_acc, m_flags);
                q_op <= cmd_op;
                q_d  <= cmd_data;
                ph   <= 1;
                cyc  <= 1;
            end
        end else if (cyc >= int'(pr.lat)) begin
            if (rsp_ready) begin
                ph <= 0;
                m_acc <= pr.acc; m_flags <= pr.flg; m_err <= pr.err;
            end
        end else begin
            cyc <= cyc + 1;
        end
    end

    logic       rv_exp, in_exec, in_mul;
    logic [3:0] exp_acc, exp_flags, exp_a, exp_b, exp_f;
    logic       exp_err;
    int         k;
    assign rv_exp    = (ph == 1) && (cyc >= int'(pr.lat));
    assign exp_acc   = rv_exp ? pr.acc : m_acc;
    assign exp_flags = rv_exp ? pr.flg : m_flags;
    assign exp_err   = rv_exp ? pr.err : m_err;
    assign in_exec   = (ph == 1) && !rv_exp && (pr.lat == 3'd2);
    assign in_mul    = (ph == 1) && !rv_exp && (pr.lat == 3'd5);
    assign k         = cyc - 1;
    assign exp_a     = in_exec ? m_acc : in_mul ? mul_partial(m_acc, q_d, k) : exp_acc;
    assign exp_b     = in_exec ? q_d : in_mul ? 4'(m_acc << k) : 4'h0;
    assign exp_f     = in_exec ? q_op : in_mul ? (q_d[k[1:0]] ? 4'h0 : 4'hF) : 4'hF;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmd_ready", int'(cmd_ready), int'(ph == 0));
            chk("busy",      int'(busy),      int'(ph != 0));
            chk("rsp_valid", int'(rsp_valid), int'(rv_exp));
            chk("acc",       int'(acc),       int'(exp_acc));
            chk("flags",     int'(flags),     int'(exp_flags));
            chk("rsp_err",   int'(rsp_err),   int'(exp_err));
            chk("alu_a",     int'(alu_a),     int'(exp_a));
            chk("alu_b",     int'(alu_b),     int'(exp_b));
            chk("alu_func",  int'(alu_func),  int'(exp_f));
        end
    end

    // ---------------- directed stimulus helpers ----------------
    // Called at a negedge with the DUT idle; returns at the first negedge
    // where rsp_valid is high, with latency in cycles and alu_func history.
    task automatic run_cmd(input logic [3:0] op, input logic [3:0] d,
                           output int lat, output logic [15:0] fs);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1; fs = '0;
        while (!rsp_valid && lat < 20) begin
            fs = {fs[11:0], alu_func};
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    int         lat;
    logic [15:0] fs;

    initial begin
        // Reset state
        #12;
        chk("rst_acc", int'(acc), 0);
        chk("rst_flags", int'(flags), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD 5, ADD 3
        run_cmd(4'hF, 4'h5, lat, fs);
        chk("load_lat", lat, 1);
        take_rsp();
        run_cmd(4'h0, 4'h3, lat, fs);
        chk("add_lat", lat, 2);
        chk("add_acc", int'(acc), 8);
        chk("add_flags", int'(flags), 5);
        chk("add_err", int'(rsp_err), 0);
        // Back-pressure: response held, stray command ignored
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_acc", int'(acc), 8);
            chk("hold_flags", int'(flags), 5);
            chk("hold_cmd_ready", int'(cmd_ready), 0);
            cmd_valid = (i == 1); cmd_op = 4'hF; cmd_data = 4'hF;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        take_rsp();
        chk("hold_no_queue", int'(busy), 0);

        // SUB to zero
        run_cmd(4'hF, 4'h8, lat, fs); take_rsp();
        run_cmd(4'h1, 4'h8, lat, fs);
        chk("sub_acc", int'(acc), 0);
        chk("sub_flags", int'(flags), 4'hA);
        take_rsp();

        // MUL 3*5 and 6*3
        run_cmd(4'hF, 4'h3, lat, fs); take_rsp();
        run_cmd(4'hC, 4'h5, lat, fs);
        chk("mul_lat", lat, 5);
        chk("mul_funcs", int'(fs), 16'h0F0F);
        chk("mul_acc", int'(acc), 4'hF);
        chk("mul_flags", int'(flags), 4'h4);
        take_rsp();
        run_cmd(4'hF, 4'h6, lat, fs); take_rsp();
        run_cmd(4'hC, 4'h3, lat, fs);
        chk("mul2_acc", int'(acc), 2);
        take_rsp();

        // Illegal opcode, then LOAD clears the error
        run_cmd(4'hF, 4'h7, lat, fs); take_rsp();
        run_cmd(4'h2, 4'h9, lat, fs);
        chk("ill_lat", lat, 1);
        chk("ill_err", int'(rsp_err), 1);
        chk("ill_acc", int'(acc), 7);
        chk("ill_flags", int'(flags), 0);
        take_rsp();
        run_cmd(4'hF, 4'h0, lat, fs);
        chk("clr_err", int'(rsp_err), 0);
        chk("load0_flags", int'(flags), 4'h8);
        take_rsp();

        // Reset during MUL step 2
        run_cmd(4'hF, 4'h3, lat, fs); take_rsp();
        cmd_valid = 1'b1; cmd_op = 4'hC; cmd_data = 4'h5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_mul_func", int'(alu_func), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_acc", int'(acc), 0);
        chk("arst_flags", int'(flags), 0);
        chk("arst_rsp_valid", int'(rsp_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(cmd_ready), 1);
        chk("post_rst_acc", int'(acc), 0);

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = 4'($urandom_range(0, 15));
            cmd_data  = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
